// File: rtl/alu_seq.sv
// Operand-issue and writeback sequencer for the 8-bit ALU: owns a small register
// file, issues one instruction at a time and writes the ALU result back.
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int N_REG   = 4,
    parameter int ALU_LAT = 1,
    localparam int RW     = $clog2(N_REG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic [3:0]       ins_op,
    input  logic [RW-1:0]    ins_rd,
    input  logic [RW-1:0]    ins_rs,
    input  logic             ins_wb,
    input  logic             wr_en,
    input  logic [RW-1:0]    wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [RW-1:0]    rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [3:0]       alu_flags,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam int CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_regs [N_REG];
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_op;
    logic [3:0]       r_flags;
    logic [RW-1:0]    r_rd;
    logic             r_wb;
    logic             r_done;
    logic             w_accept;

    // Handshake: an instruction transfers on a rising edge where ins_valid and
    // ins_ready are both high; host loads win over instruction accept in IDLE.
    assign ins_ready = (r_state == S_IDLE) && !rst && !wr_en;
    assign w_accept  = ins_valid && ins_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_flags <= '0;
            r_rd    <= '0;
            r_wb    <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < N_REG; i++) r_regs[i] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wr_en) begin
                        r_regs[wr_sel] <= wr_data;
                    end else if (w_accept) begin
                        r_a     <= r_regs[ins_rd];
                        r_b     <= r_regs[ins_rs];
                        r_op    <= ins_op;
                        r_rd    <= ins_rd;
                        r_wb    <= ins_wb;
                        r_cnt   <= CW'(ALU_LAT);
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Operands stay put; the ALU result is only trusted once the count runs out.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_flags <= alu_flags;
                        if (r_wb) r_regs[r_rd] <= alu_out;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_data   = r_regs[rd_sel];
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_op    = r_op;
    assign flags     = r_flags;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign state_dbg = r_state;

endmodule
